// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: drives the instruction-memory address, buffers
// fetched words in a 2-entry FIFO, and handles redirect/halt flow control.
module instr_fetch_ctrl #(
  parameter int unsigned          ADDR_W   = 6,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] i_mem_addr,
  input  logic [31:0]       i_mem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              halt,
  output logic              inst_valid,
  output logic [31:0]       inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  output logic [15:0]       fetch_cnt
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [1:0]        cnt_q, cnt_d;
  entry_t            ent0_q, ent0_d;
  entry_t            ent1_q, ent1_d;
  logic [CNT_W-1:0]  fetch_cnt_q, fetch_cnt_d;

  logic   deq_c;
  logic   enq_c;
  entry_t new_ent_c;

  // Handshakes; redirect suppresses enqueue, and flushes over any dequeue.
  assign deq_c     = (cnt_q != 2'd0) && inst_ready;
  assign enq_c     = (state_q == S_RUN) && !halt && !redirect_valid &&
                     ((cnt_q < 2'd2) || deq_c);
  assign new_ent_c = '{pc: pc_q, data: i_mem_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      cnt_q       <= 2'd0;
      ent0_q      <= '0;
      ent1_q      <= '0;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      ent0_q      <= ent0_d;
      ent1_q      <= ent1_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    ent0_d      = ent0_q;
    ent1_d      = ent1_q;
    fetch_cnt_d = fetch_cnt_q;

    case (state_q)
      S_IDLE:  state_d = S_RUN;
      S_RUN:   if (halt) state_d = S_HALT;
      S_HALT:  if (!halt) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase

    if (redirect_valid) begin
      state_d = S_RUN;
      pc_d    = redirect_addr;
      cnt_d   = 2'd0;
      ent0_d  = '0;
      ent1_d  = '0;
    end else begin
      // Dequeue shifts first so enqueue always writes the first free slot;
      // vacated slots are zeroed so the head reads 0 when empty.
      if (deq_c) begin
        ent0_d = ent1_q;
        ent1_d = '0;
        cnt_d  = cnt_q - 2'd1;
      end
      if (enq_c) begin
        if (cnt_d == 2'd0) ent0_d = new_ent_c;
        else               ent1_d = new_ent_c;
        cnt_d = cnt_d + 2'd1;
        pc_d  = pc_q + ADDR_W'(1);
        if (fetch_cnt_q != '1) fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
      end
    end
  end

  assign i_mem_addr = pc_q;
  assign inst_valid = (cnt_q != 2'd0);
  assign inst_data  = ent0_q.data;
  assign inst_pc    = ent0_q.pc;
  assign fetch_cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Scoreboard bench for instr_fetch_ctrl: expected pc order is queued per scenario
// and compared whenever the decode side accepts the head.
module tb_instr_fetch_ctrl;

  localparam int unsigned ADDR_W = 6;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] i_mem_addr;
  logic [31:0]       i_mem_data;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;
  logic              halt;
  logic              inst_valid;
  logic [31:0]       inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready;
  logic [15:0]       fetch_cnt;

  logic [31:0]       mem [64];
  logic [ADDR_W-1:0] exp_q [$];
  int                n_checks;
  int                n_fail;

  instr_fetch_ctrl #(.ADDR_W(ADDR_W), .RESET_PC(6'd0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_mem_addr     (i_mem_addr),
    .i_mem_data     (i_mem_data),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .halt           (halt),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .fetch_cnt      (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int k = 0; k < 64; k++) mem[k] = 32'(k + 100);
  end
  assign i_mem_data = mem[i_mem_addr];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic at_mid();
    @(negedge clk);
  endtask

  task automatic push_range(input int lo, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(6'(lo + i));
  endtask

  // Called at posedge+1; asserts reset between edges, returns at start of cycle 1.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_eq("rst_valid", 32'(inst_valid), 32'd0);
    check_eq("rst_addr", 32'(i_mem_addr), 32'd0);
    check_eq("rst_pc", 32'(inst_pc), 32'd0);
    check_eq("rst_data", inst_data, 32'd0);
    check_eq("rst_fcnt", 32'(fetch_cnt), 32'd0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  // Scoreboard: every accepted head (not cancelled by redirect) must be the next expected pc.
  always @(negedge clk) begin
    if (rst_n && inst_valid && inst_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected", 32'(inst_pc), 32'hFFFF_FFFF);
      end else begin
        logic [ADDR_W-1:0] e;
        e = exp_q.pop_front();
        check_eq("sb_pc", 32'(inst_pc), 32'(e));
        check_eq("sb_data", inst_data, 32'(e) + 32'd100);
      end
    end
  end

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst_n          = 1'b0;
    inst_ready     = 1'b0;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    next_cycle();

    // Streaming after reset release
    inst_ready = 1'b1;
    do_reset();
    push_range(0, 40);
    at_mid();
    check_eq("a_c1_valid", 32'(inst_valid), 32'd0);
    check_eq("a_c1_addr", 32'(i_mem_addr), 32'd0);
    next_cycle(); at_mid();
    check_eq("a_c2_valid", 32'(inst_valid), 32'd0);
    next_cycle(); at_mid();
    check_eq("a_c3_valid", 32'(inst_valid), 32'd1);
    check_eq("a_c3_pc", 32'(inst_pc), 32'd0);
    check_eq("a_c3_data", inst_data, 32'd100);
    repeat (11) begin next_cycle(); at_mid(); end
    check_eq("a_c14_pc", 32'(inst_pc), 32'd11);
    check_eq("a_c14_fcnt", 32'(fetch_cnt), 32'd12);

    // Fill to two entries, then reset mid-cycle; then backpressure test
    next_cycle();
    inst_ready = 1'b0;
    next_cycle();
    do_reset();
    push_range(0, 40);
    repeat (4) next_cycle();
    at_mid();
    check_eq("b_c5_valid", 32'(inst_valid), 32'd1);
    check_eq("b_c5_pc", 32'(inst_pc), 32'd0);
    check_eq("b_c5_addr", 32'(i_mem_addr), 32'd2);
    check_eq("b_c5_fcnt", 32'(fetch_cnt), 32'd2);
    next_cycle();
    inst_ready = 1'b1;
    at_mid();
    check_eq("b_c6_addr", 32'(i_mem_addr), 32'd2);
    repeat (3) next_cycle();
    at_mid();
    check_eq("b_c9_pc", 32'(inst_pc), 32'd3);

    // Redirect with two entries buffered
    do_reset();
    push_range(0, 40);
    repeat (6) next_cycle();
    inst_ready = 1'b0;
    next_cycle();
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr  = 6'd11;
    exp_q.delete();
    push_range(11, 30);
    at_mid();
    check_eq("c_c8_pc", 32'(inst_pc), 32'd4);
    check_eq("c_c8_addr", 32'(i_mem_addr), 32'd6);
    next_cycle();
    redirect_valid = 1'b0;
    at_mid();
    check_eq("c_c9_valid", 32'(inst_valid), 32'd0);
    check_eq("c_c9_addr", 32'(i_mem_addr), 32'd11);
    next_cycle(); at_mid();
    check_eq("c_c10_pc", 32'(inst_pc), 32'd11);
    repeat (3) begin next_cycle(); at_mid(); end

    // Redirect near the top of the address space, then halt
    do_reset();
    next_cycle();
    next_cycle();
    redirect_valid = 1'b1;
    redirect_addr  = 6'd62;
    exp_q.delete();
    push_range(62, 33);
    next_cycle();
    redirect_valid = 1'b0;
    at_mid();
    check_eq("d_c4_valid", 32'(inst_valid), 32'd0);
    check_eq("d_c4_addr", 32'(i_mem_addr), 32'd62);
    next_cycle(); at_mid();
    check_eq("d_c5_pc", 32'(inst_pc), 32'd62);
    next_cycle();
    next_cycle(); at_mid();
    check_eq("d_wrap_pc", 32'(inst_pc), 32'd0);
    next_cycle();
    next_cycle();
    halt = 1'b1;
    at_mid();
    check_eq("e_c9_fcnt", 32'(fetch_cnt), 32'd6);
    for (int i = 0; i < 3; i++) begin
      next_cycle(); at_mid();
      check_eq("e_halt_valid", 32'(inst_valid), 32'd0);
      check_eq("e_halt_addr", 32'(i_mem_addr), 32'd3);
      check_eq("e_halt_fcnt", 32'(fetch_cnt), 32'd6);
    end
    next_cycle();
    halt = 1'b0;
    at_mid();
    check_eq("e_c13_valid", 32'(inst_valid), 32'd0);
    check_eq("e_c13_addr", 32'(i_mem_addr), 32'd3);
    next_cycle(); at_mid();
    check_eq("e_c14_addr", 32'(i_mem_addr), 32'd3);
    next_cycle(); at_mid();
    check_eq("e_c15_pc", 32'(inst_pc), 32'd3);
    check_eq("e_c15_fcnt", 32'(fetch_cnt), 32'd7);
    repeat (3) begin next_cycle(); at_mid(); end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 6'd0: word address of the first fetch after reset.
REQ-002 Parameter ADDR_W, default 6: word-address width, which matches the 64-entry instruction memory.
REQ-003 Port clk, input, 1: single clock; all state updates occur on the rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port i_mem_addr, output, ADDR_W: word address driven to the instruction memory; equals the PC register.
REQ-006 Port i_mem_data, input, 32: combinational read data of the memory for the current i_mem_addr.
REQ-007 Port redirect_valid, input, 1: one-cycle branch/jump redirect request.
REQ-008 Port redirect_addr, input, ADDR_W: word target of the redirect.
REQ-009 Port halt, input, 1: level request to stop fetching.
REQ-010 Port inst_valid, output, 1: the buffer head holds a valid instruction.
REQ-011 Port inst_data, output, 32: instruction word at the buffer head.
REQ-012 Port inst_pc, output, ADDR_W: word address of inst_data.
REQ-013 Port inst_ready, input, 1: the decode stage accepts the head this cycle.
REQ-014 Port fetch_cnt, output, 16: count of instructions enqueued since reset.

Function
REQ-015 The block SHALL hold a 2-entry FIFO of {pc, instruction}, a PC register, and a state register with states IDLE, RUN and HALT.
REQ-016 Deq SHALL be asserted when inst_valid and inst_ready are both 1; inst_valid SHALL be 1 exactly when the FIFO count is nonzero.
REQ-017 Enq SHALL be asserted when the state is RUN, halt=0, redirect_valid=0, and either count<2 or (count==2 and deq).
REQ-018 On enq, the FIFO SHALL capture {i_mem_addr, i_mem_data}, and the PC SHALL advance to PC+1 modulo 2^ADDR_W (63 wraps to 0).
REQ-019 Latency: an address presented in cycle N SHALL appear at the head no earlier than cycle N+1 if the FIFO was empty.
REQ-020 With simultaneous enq and deq, count SHALL be unchanged and order SHALL be preserved; with count==2 and no deq, there is no enq and the PC holds.
REQ-021 A redirect SHALL have the highest priority:
  - the FIFO is flushed (count=0 at the next edge) and any same-cycle deq is ignored;
  - PC <= redirect_addr;
  - no enq occurs that cycle;
  - the state goes to RUN even from HALT.
REQ-022 State transitions SHALL be:
  - IDLE -> RUN unconditionally one cycle after reset release, with no enq in IDLE;
  - RUN -> HALT when halt=1 and redirect_valid=0;
  - HALT -> RUN when halt=0.
REQ-023 In HALT, the PC SHALL hold, no enq SHALL occur, and the FIFO SHALL still drain via deq.
REQ-024 fetch_cnt SHALL increment by 1 per enq, saturate at 16'hFFFF, and not be cleared by redirect.
REQ-025 inst_data and inst_pc SHALL show the head entry and be 0 when count==0.

Reset
REQ-026 While rst_n=0, the block SHALL immediately force:
  - state=IDLE, PC=RESET_PC, count=0, FIFO contents=0, fetch_cnt=0;
  - therefore i_mem_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0.
REQ-027 A reset asserted mid-operation SHALL discard all buffered instructions, with no partial state retained.

Verification
REQ-028 Release reset with inst_ready=1 and mem[k]=k+100 -> cycle 1 IDLE; inst_pc 0,1,2,... on consecutive cycles from cycle 3 with inst_data 100,101,102,...
REQ-029 Hold inst_ready=0 for 5 cycles after start -> count reaches 2 and holds, PC frozen at 2; release -> pcs 0,1,2,3 delivered in order without gaps or duplicates.
REQ-030 Redirect to 11 while the FIFO holds pcs 4,5 and inst_ready=1 -> next cycle inst_valid=0; the following cycle inst_pc=11, and pcs 4,5 are never re-presented after the flush.
REQ-031 Start PC at 62 via redirect -> sequence 62, 63, 0, 1.
REQ-032 Assert halt for 4 cycles with inst_ready=1 -> FIFO drains to empty, PC stable, fetch_cnt stable; deassert -> fetch resumes at the held PC.
REQ-033 Assert rst_n=0 asynchronously between edges with count=2 -> inst_valid=0 and i_mem_addr=RESET_PC before the next clock edge.
